// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice plus carry flop, LSB first, one bit per clock.
// Optional SERIAL_ADD_OVF_EN macro adds a signed-overflow output `ovf`.
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_nxt;
`ifdef SERIAL_ADD_OVF_EN
  logic             carry_msb;
`endif

  // The single full-adder slice.
  assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (cnt == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: operand and accumulator registers are reset too, so no X ever reaches the adder slice.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      carry_msb <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= {sum_bit, acc[WIDTH-1:1]};
          carry <= carry_nxt;
          cnt   <= cnt + 1'b1;
`ifdef SERIAL_ADD_OVF_EN
          // Carry entering the MSB slice, kept for the overflow compare.
          if (cnt == LAST) carry_msb <= carry;
`endif
        end
        DONE: begin
          // Result registers are separate from acc so partial sums never show on sum/cout.
          sum  <= acc;
          cout <= carry;
          done <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
          ovf  <= carry_msb ^ carry;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=4 and WIDTH=5 instances).
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic       start5, cin5, busy5, done5, cout5;
  logic [4:0] a5, b5, sum5;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf4, ovf5;
`endif

  serial_add_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf4)
`endif
  );

  serial_add_ctrl #(.WIDTH(5)) u5 (
    .clk(clk), .reset(reset), .start(start5), .a_in(a5), .b_in(b5), .cin(cin5),
    .busy(busy5), .done(done5), .sum(sum5), .cout(cout5)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf5)
`endif
  );

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;
  int n0;

  always @(negedge clk) if (done4) done_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_add4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int lat;
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    tick;
    start4 = 1'b0;
    check("busy4_after_accept", 32'(busy4), 32'd1);
    lat = 0;
    while (!done4 && lat < 20) begin
      tick;
      lat++;
    end
    check("latency4", lat, 32'd5);
  endtask

  task automatic do_add5(input logic [4:0] a, input logic [4:0] b, input logic c);
    int lat;
    a5 = a; b5 = b; cin5 = c; start5 = 1'b1;
    tick;
    start5 = 1'b0;
    lat = 0;
    while (!done5 && lat < 20) begin
      tick;
      lat++;
    end
    check("latency5", lat, 32'd6);
  endtask

  initial begin
    reset = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start5 = 1'b0; a5 = '0; b5 = '0; cin5 = 1'b0;
    tick;
    tick;
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_sum", 32'(sum4), 32'd0);
    check("rst_cout", 32'(cout4), 32'd0);
    check("rst_sum5", 32'(sum5), 32'd0);
    reset = 1'b1;
    tick;

    // 15 + 11 + 1 = 27
    do_add4(4'b1111, 4'b1011, 1'b1);
    check("add27_sum", 32'(sum4), 32'b1011);
    check("add27_cout", 32'(cout4), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
    check("add27_ovf", 32'(ovf4), 32'd0);
`endif
    tick;
    check("done_one_cycle", 32'(done4), 32'd0);
    check("idle_busy", 32'(busy4), 32'd0);
    check("add27_hold", 32'(sum4), 32'b1011);

    // 27 + 17 + 1 = 45 on the 5-bit instance
    do_add5(5'b11011, 5'b10001, 1'b1);
    check("add45_sum", 32'(sum5), 32'b01101);
    check("add45_cout", 32'(cout5), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
    check("add45_ovf", 32'(ovf5), 32'd1);
`endif

    // 7 + 1 = 8
    do_add4(4'b0111, 4'b0001, 1'b0);
    check("add8_sum", 32'(sum4), 32'b1000);
    check("add8_cout", 32'(cout4), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("add8_ovf", 32'(ovf4), 32'd1);
`endif

    // Re-pulsed start and changed operands while busy: 3 + 4 only
    a4 = 4'b0011; b4 = 4'b0100; cin4 = 1'b0; start4 = 1'b1;
    tick;
    start4 = 1'b0;
    tick;
    n0 = done_cnt;
    start4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b1;
    tick;
    tick;
    start4 = 1'b0;
    repeat (6) tick;
    check("ignore_start_pulses", done_cnt - n0, 32'd1);
    check("ignore_start_sum", 32'(sum4), 32'b0111);
    check("ignore_start_cout", 32'(cout4), 32'd0);
    check("ignore_start_idle", 32'(busy4), 32'd0);

    // Reset during the second SHIFT cycle aborts the operation
    a4 = 4'b0101; b4 = 4'b0101; cin4 = 1'b0; start4 = 1'b1;
    tick;
    start4 = 1'b0;
    check("shift_sum_hidden", 32'(sum4), 32'b0111);
    tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_done", 32'(done4), 32'd0);
    check("abort_sum", 32'(sum4), 32'd0);
    check("abort_cout", 32'(cout4), 32'd0);
    n0 = done_cnt;
    repeat (8) tick;
    check("abort_no_done", done_cnt - n0, 32'd0);
    do_add4(4'b0001, 4'b0001, 1'b0);
    check("post_abort_sum", 32'(sum4), 32'b0010);
    check("post_abort_cout", 32'(cout4), 32'd0);
    tick;

    // start held high across three back-to-back operations
    a4 = 4'b0001; b4 = 4'b0010; cin4 = 1'b0; start4 = 1'b1;
    n0 = done_cnt;
    tick;
    a4 = 4'b0110; b4 = 4'b0111; cin4 = 1'b1;
    repeat (4) tick;
    check("b2b_no_early_done", 32'(done4), 32'd0);
    tick;
    check("b2b1_done", 32'(done4), 32'd1);
    check("b2b1_sum", 32'(sum4), 32'b0011);
    check("b2b1_cout", 32'(cout4), 32'd0);
    tick;
    a4 = 4'b1001; b4 = 4'b1000; cin4 = 1'b1;
    repeat (5) tick;
    check("b2b2_done", 32'(done4), 32'd1);
    check("b2b2_sum", 32'(sum4), 32'b1110);
    check("b2b2_cout", 32'(cout4), 32'd0);
    tick;
    start4 = 1'b0;
    repeat (5) tick;
    check("b2b3_done", 32'(done4), 32'd1);
    check("b2b3_sum", 32'(sum4), 32'b0010);
    check("b2b3_cout", 32'(cout4), 32'd1);
    repeat (3) tick;
    check("b2b_pulse_count", done_cnt - n0, 32'd3);
    check("b2b_final_idle", 32'(busy4), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
